// File: rtl/mask_downsampler.sv
// Reduces a binary colour-threshold mask to one mark per 4x4 pixel block, streamed in raster order.
// One accumulator per block column carries partial sums across the four rows of a block row.
module mask_downsampler #(
  parameter int IN_WIDTH  = 1280,
  parameter int IN_HEIGHT = 720,
  parameter int THRESHOLD = 8
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        mask_in,
  input  logic        pixel_valid_in,
  output logic [8:0]  x_out,
  output logic [7:0]  y_out,
  output logic        mask_out,
  output logic        valid_out,
  output logic        new_frame_out
);

  localparam int          BLK_W     = IN_WIDTH / 4;
  localparam int          BLK_H     = IN_HEIGHT / 4;
  localparam logic [15:0] BLK_TOTAL = 16'(BLK_W * BLK_H);
  localparam logic [8:0]  LAST_X    = 9'(BLK_W - 1);
  localparam logic [7:0]  LAST_Y    = 8'(BLK_H - 1);
  localparam logic [4:0]  THRESH    = 5'(THRESHOLD);

  typedef enum logic {UNSYNCED, RUN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  acc_q [BLK_W];
  logic        valid_q, valid_d;
  logic        new_frame_q, new_frame_d;
  logic        mask_q, mask_d;
  logic [8:0]  x_q, x_d;
  logic [7:0]  y_q, y_d;
  logic [15:0] count_q, count_d;

  logic        accept, origin, active, first_px, last_px;
  logic [8:0]  bx;
  logic [7:0]  by;
  logic [4:0]  base, sum, acc_wr;

  always_comb begin
    bx       = hcount_in[10:2];
    by       = vcount_in[9:2];
    accept   = pixel_valid_in && (int'(hcount_in) < IN_WIDTH) && (int'(vcount_in) < IN_HEIGHT);
    origin   = accept && (hcount_in == 11'd0) && (vcount_in == 10'd0);
    // The sync pixel itself already counts as part of the new frame.
    active   = accept && ((state_q == RUN) || origin);
    first_px = (hcount_in[1:0] == 2'd0) && (vcount_in[1:0] == 2'd0);
    last_px  = (hcount_in[1:0] == 2'd3) && (vcount_in[1:0] == 2'd3);
    base     = first_px ? 5'd0 : acc_q[bx];
    sum      = base + {4'd0, mask_in};
    acc_wr   = (sum > 5'd16) ? 5'd16 : sum;
  end

  always_comb begin
    state_d     = state_q;
    valid_d     = 1'b0;
    new_frame_d = 1'b0;
    mask_d      = mask_q;
    x_d         = x_q;
    y_d         = y_q;
    count_d     = count_q;
    if (origin) begin
      state_d = RUN;
      count_d = 16'd0;
    end
    if (active && last_px) begin
      valid_d = 1'b1;
      x_d     = bx;
      y_d     = by;
      mask_d  = (acc_wr >= THRESH);
      count_d = count_q + 16'd1;
    end
    // count_q already includes the final block when its strobe is on the output.
    if (valid_q && (x_q == LAST_X) && (y_q == LAST_Y) && (count_q == BLK_TOTAL)) begin
      new_frame_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= UNSYNCED;
      valid_q     <= 1'b0;
      new_frame_q <= 1'b0;
      mask_q      <= 1'b0;
      x_q         <= 9'd0;
      y_q         <= 8'd0;
      count_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      new_frame_q <= new_frame_d;
      mask_q      <= mask_d;
      x_q         <= x_d;
      y_q         <= y_d;
      count_q     <= count_d;
    end
  end

  // Accumulators are reloaded at each block's first pixel, so they need no reset.
  always_ff @(posedge clk_in) begin
    if (active) begin
      acc_q[bx] <= acc_wr;
    end
  end

  assign valid_out     = valid_q;
  assign new_frame_out = new_frame_q;
  assign mask_out      = mask_q;
  assign x_out         = x_q;
  assign y_out         = y_q;

endmodule

// File: tb/tb_mask_downsampler.sv
// Randomised bench for mask_downsampler on a reduced 32x16 frame, checked cycle by cycle
// against an image-based reference that sums each 4x4 block directly.
module tb_mask_downsampler;

  localparam int W     = 32;
  localparam int H     = 16;
  localparam int THR   = 8;
  localparam int BW    = W / 4;
  localparam int BH    = H / 4;
  localparam int TOTAL = BW * BH;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hc;
  logic [9:0]  vc;
  logic        m;
  logic        pv;
  logic [8:0]  x_out;
  logic [7:0]  y_out;
  logic        mask_out;
  logic        valid_out;
  logic        new_frame_out;

  mask_downsampler #(.IN_WIDTH(W), .IN_HEIGHT(H), .THRESHOLD(THR)) dut (
    .clk_in(clk),
    .rst_in(rst),
    .hcount_in(hc),
    .vcount_in(vc),
    .mask_in(m),
    .pixel_valid_in(pv),
    .x_out(x_out),
    .y_out(y_out),
    .mask_out(mask_out),
    .valid_out(valid_out),
    .new_frame_out(new_frame_out)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference state: the mask image seen since sync, plus last emitted block.
  int img     [H][W];
  int rnd_img [H][W];
  bit synced;
  int blk_cnt;
  bit nf_pend;
  int lx, ly, lm;
  int seg_strobes, seg_ones, seg_nf;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    synced  = 1'b0;
    blk_cnt = 0;
    nf_pend = 1'b0;
    lx = 0;
    ly = 0;
    lm = 0;
  endtask

  task automatic seg_clear();
    seg_strobes = 0;
    seg_ones    = 0;
    seg_nf      = 0;
  endtask

  task automatic step(input bit v, input int h, input int r, input bit mk);
    bit acc;
    bit ev;
    bit enf;
    int tot;
    @(negedge clk);
    pv = v;
    hc = 11'(h);
    vc = 10'(r);
    m  = mk;
    enf     = nf_pend;
    nf_pend = 1'b0;
    ev      = 1'b0;
    acc     = v && (h < W) && (r < H);
    if (acc && h == 0 && r == 0) begin
      synced  = 1'b1;
      blk_cnt = 0;
    end
    if (acc && synced) begin
      img[r][h] = mk;
      if ((h % 4 == 3) && (r % 4 == 3)) begin
        tot = 0;
        for (int dy = 0; dy < 4; dy++)
          for (int dx = 0; dx < 4; dx++)
            tot += img[r-dy][h-dx];
        ev = 1'b1;
        lx = h / 4;
        ly = r / 4;
        lm = (tot >= THR) ? 1 : 0;
        blk_cnt++;
        if (lx == BW-1 && ly == BH-1 && blk_cnt == TOTAL) nf_pend = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    check("valid_out", int'(valid_out), int'(ev));
    check("new_frame_out", int'(new_frame_out), int'(enf));
    check("x_out", int'(x_out), lx);
    check("y_out", int'(y_out), ly);
    check("mask_out", int'(mask_out), lm);
    if (valid_out) seg_strobes++;
    if (valid_out && mask_out) seg_ones++;
    if (new_frame_out) seg_nf++;
  endtask

  task automatic junk();
    int k;
    k = int'($urandom_range(2));
    case (k)
      0: step(1'b0, int'($urandom_range(2047)), int'($urandom_range(1023)), 1'($urandom_range(1)));
      1: step(1'b1, W + int'($urandom_range(2047 - W)), int'($urandom_range(H-1)), 1'($urandom_range(1)));
      default: step(1'b1, int'($urandom_range(W-1)), H + int'($urandom_range(1023 - H)), 1'($urandom_range(1)));
    endcase
  endtask

  function automatic bit pix_mask(input int pat, input int r, input int c, input int n);
    case (pat)
      0: return 1'b1;
      1: return rnd_img[r][c] != 0;
      2: return (c / 4 == 5) && (r / 4 == 2) && ((r % 4) * 4 + (c % 4) < n);
      default: return 1'b0;
    endcase
  endfunction

  task automatic run_rows(input int pat, input int gap_pct, input int r0, input int r1, input int n);
    for (int r = r0; r < r1; r++) begin
      for (int c = 0; c < W; c++) begin
        while (int'($urandom_range(99)) < gap_pct) junk();
        step(1'b1, c, r, pix_mask(pat, r, c, n));
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    pv  = 1'b0;
    #1;
    model_reset();
    check("rst_valid", int'(valid_out), 0);
    check("rst_new_frame", int'(new_frame_out), 0);
    check("rst_x", int'(x_out), 0);
    check("rst_y", int'(y_out), 0);
    check("rst_mask", int'(mask_out), 0);
    @(posedge clk);
    #1;
    check("rst_hold_valid", int'(valid_out), 0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    pv  = 1'b0;
    hc  = '0;
    vc  = '0;
    m   = 1'b0;
    model_reset();
    seg_clear();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        img[r][c]     = 0;
        rnd_img[r][c] = int'($urandom_range(1));
      end
    repeat (2) @(posedge clk);
    #1;
    check("init_valid", int'(valid_out), 0);
    check("init_new_frame", int'(new_frame_out), 0);
    check("init_x", int'(x_out), 0);
    check("init_y", int'(y_out), 0);
    check("init_mask", int'(mask_out), 0);
    @(negedge clk);
    rst = 1'b0;

    // Unsynced stream without an origin pixel produces nothing.
    seg_clear();
    run_rows(0, 10, 4, H, 0);
    check("unsynced_strobes", seg_strobes, 0);

    // All-ones frame.
    seg_clear();
    run_rows(0, 0, 0, H, 0);
    idle(2);
    check("ones_strobes", seg_strobes, TOTAL);
    check("ones_marks", seg_ones, TOTAL);
    check("ones_new_frame", seg_nf, 1);

    // Exactly THR ones in block (5,2), then one fewer.
    seg_clear();
    run_rows(2, 0, 0, H, THR);
    idle(2);
    check("thr_marks", seg_ones, 1);
    check("thr_new_frame", seg_nf, 1);
    seg_clear();
    run_rows(2, 0, 0, H, THR - 1);
    idle(2);
    check("below_thr_marks", seg_ones, 0);

    // Random image with gaps and out-of-range pixels, two frames back to back.
    seg_clear();
    run_rows(1, 30, 0, H, 0);
    run_rows(1, 30, 0, H, 0);
    idle(2);
    check("gap_strobes", seg_strobes, 2 * TOTAL);
    check("gap_new_frame", seg_nf, 2);

    // Reset mid-frame, resume part-way down: silent until next origin.
    run_rows(0, 0, 0, 8, 0);
    do_reset();
    seg_clear();
    run_rows(0, 5, 8, H, 0);
    check("post_rst_strobes", seg_strobes, 0);
    check("post_rst_new_frame", seg_nf, 0);
    seg_clear();
    run_rows(1, 10, 0, H, 0);
    idle(2);
    check("resync_strobes", seg_strobes, TOTAL);
    check("resync_new_frame", seg_nf, 1);

    // Origin injected mid-frame truncates the running frame.
    seg_clear();
    run_rows(0, 0, 0, 8, 0);
    run_rows(1, 0, 0, H, 0);
    idle(2);
    check("abort_strobes", seg_strobes, 2 * BW + TOTAL);
    check("abort_new_frame", seg_nf, 1);
    seg_clear();
    run_rows(2, 20, 0, H, THR + 3);
    idle(2);
    check("after_abort_new_frame", seg_nf, 1);
    check("after_abort_marks", seg_ones, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mask_downsampler.md
MASK_DOWNSAMPLER -- requirements
Module: mask_downsampler

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 1280, input frame width in pixels.
REQ-002 SHALL have parameter IN_HEIGHT, default 720, input frame height in pixels.
REQ-003 SHALL have parameter THRESHOLD, default 8, minimum set pixels (1..16) per 4x4 block for the block to be marked.
REQ-004 SHALL have port clk_in  input  1  system clock; one clock, all logic on its rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous and active-high.
REQ-006 SHALL have port hcount_in  input  11  input pixel column.
REQ-007 SHALL have port vcount_in  input  10  input pixel row.
REQ-008 SHALL have port mask_in  input  1  color-threshold mask bit of the current pixel.
REQ-009 SHALL have port pixel_valid_in  input  1  qualifies hcount_in/vcount_in/mask_in this cycle.
REQ-010 SHALL have port x_out  output  9  block column, 0..IN_WIDTH/4-1.
REQ-011 SHALL have port y_out  output  8  block row, 0..IN_HEIGHT/4-1.
REQ-012 SHALL have port mask_out  output  1  block mark, the data_valid input of the clustering stage.
REQ-013 SHALL have port valid_out  output  1  one-cycle strobe: x_out/y_out/mask_out carry a completed block.
REQ-014 SHALL have port new_frame_out  output  1  one-cycle pulse at end of each complete downsampled frame.

Function
REQ-015 SHALL accept only pixels with pixel_valid_in=1, hcount_in<IN_WIDTH and vcount_in<IN_HEIGHT; all others are ignored with no state change.
REQ-016 SHALL map an accepted pixel to block bx=hcount_in>>2, by=vcount_in>>2; pixels arrive in raster order, gaps allowed.
REQ-017 SHALL keep one 5-bit accumulator per block column (IN_WIDTH/4 entries), range 0..16, never wrapping.
REQ-018 SHALL load acc[bx]=mask_in when vcount_in[1:0]=0 and hcount_in[1:0]=0; otherwise acc[bx]=acc[bx]+mask_in.
REQ-019 SHALL treat the pixel with vcount_in[1:0]=3 and hcount_in[1:0]=3 as block completion; the block total includes that pixel's mask_in.
REQ-020 SHALL, one cycle after a completion pixel, assert valid_out=1 for exactly one cycle with x_out=bx, y_out=by, mask_out=(total>=THRESHOLD).
REQ-021 SHALL hold x_out, y_out, mask_out at their last values while valid_out=0.
REQ-022 SHALL keep a sync FSM with states UNSYNCED and RUN; reset enters UNSYNCED.
REQ-023 SHALL move UNSYNCED->RUN on an accepted pixel at hcount_in=0, vcount_in=0; that pixel is accumulated normally.
REQ-024 SHALL, in UNSYNCED, accumulate nothing and suppress valid_out and new_frame_out.
REQ-025 SHALL keep a 16-bit count of blocks emitted in the current frame, cleared on entry to RUN and on each accepted pixel at (0,0).
REQ-026 SHALL assert new_frame_out for one cycle, the cycle after valid_out for block (IN_WIDTH/4-1, IN_HEIGHT/4-1), only if the block count then equals (IN_WIDTH/4)*(IN_HEIGHT/4); otherwise no pulse that frame.
REQ-027 SHALL, when (0,0) arrives mid-frame in RUN, restart the frame: count cleared, no new_frame_out for the truncated frame.
REQ-028 SHALL sustain one accepted pixel per cycle with no backpressure.

Reset
REQ-029 SHALL, while rst_in=1, immediately drive valid_out=0, new_frame_out=0, mask_out=0, x_out=0, y_out=0, block count 0, FSM UNSYNCED.
REQ-030 SHALL NOT require accumulator contents to be reset; they are initialised by REQ-018 before use.
REQ-031 SHALL, on rst_in asserted mid-frame, discard the frame; output resumes only after the next (0,0) pixel.

Verification
REQ-032 All-ones full frame after (0,0) sync -> 57600 valid_out strobes, all mask_out=1, raster order, one new_frame_out the cycle after block (319,179).
REQ-033 All-zero frame except 8 ones inside block (5,2) -> only that strobe has mask_out=1; with 7 ones -> all mask_out=0.
REQ-034 Completion pixel (hcount 23, vcount 11) at cycle N -> valid_out at N+1 with x_out=5, y_out=2.
REQ-035 Reset mid-frame, stream resumed at row 300 -> zero strobes until next (0,0), then normal frame with new_frame_out.
REQ-036 Random pixel_valid_in gaps and pixels with hcount_in>=1280 or vcount_in>=720 -> identical mask_out sequence to gap-free reference run.
REQ-037 (0,0) injected at row 400 of a running frame -> no new_frame_out for the aborted frame; next full frame pulses once.
